// File: rtl/keypad_time_entry.sv
// Keypad time entry: shifts keypad digits into an M:SS buffer, validates it
// on start, loads it into the downstream timer digit chain with a one-cycle
// active-low load, then keeps the chain enabled until it reports zero or the
// user cancels.
module keypad_time_entry #(
  parameter int MAX_DIGITS   = 3,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_zero,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       loadn,
  output logic       timer_en,
  output logic       busy,
  output logic [1:0] digit_count,
  output logic       err,
  output logic       done,
  output logic       stop
);

  typedef enum logic [1:0] {IDLE, ENTRY, LOAD, RUN} state_t;

  localparam logic [1:0] MAX_CNT  = 2'(MAX_DIGITS);
  localparam logic [3:0] TENS_MAX = 4'(SEC_TENS_MAX);

  state_t     state_reg, state_next;
  logic [3:0] ones_reg, ones_next;
  logic [3:0] tens_reg, tens_next;
  logic [3:0] min_reg, min_next;
  logic [1:0] count_reg, count_next;
  logic       err_reg, err_next;
  logic       done_reg, done_next;
  logic       stop_reg, stop_next;
  // High during the first RUN cycle, when the chain has only just been loaded
  // and timer_zero still reflects its pre-load contents.
  logic       first_reg, first_next;

  logic key_ok;
  logic start_ok;

  assign key_ok   = key_valid && (key_digit <= 4'd9) && (count_reg < MAX_CNT);
  assign start_ok = (tens_reg <= TENS_MAX) &&
                    ({min_reg, tens_reg, ones_reg} != 12'd0);

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Buffer, digit count, run-start flag and registered pulses.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ones_reg  <= 4'd0;
      tens_reg  <= 4'd0;
      min_reg   <= 4'd0;
      count_reg <= 2'd0;
      err_reg   <= 1'b0;
      done_reg  <= 1'b0;
      stop_reg  <= 1'b0;
      first_reg <= 1'b0;
    end else begin
      ones_reg  <= ones_next;
      tens_reg  <= tens_next;
      min_reg   <= min_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      done_reg  <= done_next;
      stop_reg  <= stop_next;
      first_reg <= first_next;
    end
  end

  // Next-state and datapath decisions; cancel beats start beats key_valid.
  always_comb begin
    state_next = state_reg;
    ones_next  = ones_reg;
    tens_next  = tens_reg;
    min_next   = min_reg;
    count_next = count_reg;
    err_next   = 1'b0;
    done_next  = 1'b0;
    stop_next  = 1'b0;
    first_next = 1'b0;
    case (state_reg)
      IDLE, ENTRY: begin
        if (cancel) begin
          ones_next  = 4'd0;
          tens_next  = 4'd0;
          min_next   = 4'd0;
          count_next = 2'd0;
          state_next = IDLE;
        end else if (start) begin
          if (state_reg == IDLE || !start_ok) begin
            err_next = 1'b1;
          end else begin
            state_next = LOAD;
          end
        end else if (key_ok) begin
          min_next   = tens_reg;
          tens_next  = ones_reg;
          ones_next  = key_digit;
          count_next = count_reg + 2'd1;
          state_next = ENTRY;
        end
      end
      LOAD: begin
        state_next = RUN;
        first_next = 1'b1;
      end
      RUN: begin
        if (cancel || (timer_zero && !first_reg)) begin
          stop_next  = cancel;
          done_next  = !cancel;
          ones_next  = 4'd0;
          tens_next  = 4'd0;
          min_next   = 4'd0;
          count_next = 2'd0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Chain control decoded purely from the state flops.
  always_comb begin
    loadn    = (state_reg != LOAD);
    timer_en = (state_reg == LOAD) || (state_reg == RUN);
    busy     = (state_reg == LOAD) || (state_reg == RUN);
  end

  assign sec_ones    = ones_reg;
  assign sec_tens    = tens_reg;
  assign min_ones    = min_reg;
  assign digit_count = count_reg;
  assign err         = err_reg;
  assign done        = done_reg;
  assign stop        = stop_reg;

endmodule

// File: doc/keypad_time_entry.md
Name: keypad_time_entry

Overview:
- Upstream stage of the microwave countdown chain: collects keypad digit strobes into an M:SS buffer (minute units, seconds tens, seconds units).
- On start, validates the buffer and drives it into the timer digit chain with a one-cycle active-low load.
- Holds the chain enabled while running, and returns to idle when the chain reports all-zero or the user cancels.

Parameters:
- MAX_DIGITS, 3, maximum digits accepted per entry (legal 1..3); further digits ignored
- SEC_TENS_MAX, 5, largest legal seconds-tens digit (mod-6 digit downstream)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  reset, asynchronous, active-high
- key_valid  in  1  one-cycle strobe: key_digit is valid
- key_digit  in  4  pressed digit; values 10..15 ignored
- start  in  1  one-cycle start strobe
- cancel  in  1  one-cycle cancel/clear strobe
- timer_zero  in  1  high when every downstream timer digit is zero
- sec_ones  out  4  buffer seconds units / load data
- sec_tens  out  4  buffer seconds tens / load data
- min_ones  out  4  buffer minute units / load data
- loadn  out  1  active-low load to timer digits
- timer_en  out  1  enable to timer digits
- busy  out  1  high in LOAD and RUN
- digit_count  out  2  digits accepted so far (0..MAX_DIGITS)
- err  out  1  one-cycle pulse: start rejected
- done  out  1  one-cycle pulse: countdown reached zero
- stop  out  1  one-cycle pulse: run cancelled

Behaviour:
- Reset (clr high, any time, mid-run included):
  - state IDLE; all digits 0; digit_count 0
  - loadn 1; timer_en 0; busy/err/done/stop 0
  - Takes effect without a clock edge.
- All other updates occur on the rising edge of clk.
- Pulse outputs (err, done, stop) are registered, high for exactly one cycle, and default low.
- States:
  - IDLE: buffer empty.
  - ENTRY: 1..MAX_DIGITS digits held.
  - LOAD: one cycle.
  - RUN: counting down.
- Digit accept (IDLE or ENTRY, key_valid, key_digit<=9, digit_count<MAX_DIGITS):
  - min_ones<=sec_tens; sec_tens<=sec_ones; sec_ones<=key_digit
  - digit_count++; state ENTRY
  - At digit_count==MAX_DIGITS the key is ignored and the buffer is unchanged.
  - key_digit>9 is ignored.
- Priority within one cycle: cancel > start > key_valid. A lower-priority strobe in the same cycle is discarded, not deferred.
- cancel in IDLE/ENTRY: buffer and digit_count cleared; state IDLE; no pulse.
- start in IDLE: err pulse; stay IDLE.
- start in ENTRY:
  - Rejected if sec_tens>SEC_TENS_MAX, or all three digits are 0.
  - On reject: err pulse next cycle; buffer kept; stay ENTRY.
  - Otherwise: next state LOAD.
- LOAD (exactly one cycle):
  - loadn=0, timer_en=1, busy=1; digit outputs stable.
  - The downstream chain captures the data on the edge ending LOAD.
  - Next state RUN.
- RUN:
  - loadn=1, timer_en=1, busy=1; buffer frozen; key_valid and start ignored.
  - timer_zero sampled high: done pulse; buffer and digit_count cleared; timer_en 0; state IDLE.
  - timer_zero is ignored in the first RUN cycle, because the chain is just loaded.
  - cancel: stop pulse; buffer cleared; timer_en 0; state IDLE.
  - cancel and timer_zero in the same cycle: cancel wins; stop pulses, done does not.
- loadn, timer_en and busy are registered outputs (decoded from state flops, not inputs).
- Widths: digit_count saturates at MAX_DIGITS; no wrap.

Test Plan:
- Reset then keys 1,3,0, start:
  - sec_ones=0, sec_tens=3, min_ones=1, digit_count=3.
  - LOAD cycle: loadn=0, timer_en=1.
  - Then RUN with busy=1.
  - Assert timer_zero three cycles later -> done pulse 1 cycle, all digits 0, state IDLE.
- Keys 7,5 then start -> buffer 0:75, err pulse, loadn stays 1, state ENTRY.
  - Then cancel -> buffer 0, digit_count 0.
- Keys 4,2,9,8 -> fourth ignored; buffer 4:29, digit_count=3.
  - key_digit=12 strobe -> no change.
- Same-cycle strobes:
  - key_valid(5)+start with buffer 0:0 (digit_count=1) -> start processed first, err pulse (all zero), digit 5 discarded.
  - start+cancel in ENTRY -> buffer cleared, no LOAD.
- RUN with cancel and timer_zero together -> stop=1, done=0, timer_en 0, IDLE.
  - A key_valid during RUN leaves the buffer unchanged.
- Assert clr asynchronously mid-RUN (between edges) -> outputs return to reset values immediately; timer_en 0, loadn 1, busy 0.
